// File: rtl/reg_file_param.sv
// Parameterised register file: three combinational read ports, two write ports,
// optional same-cycle write forwarding, and a one-register-per-cycle clear engine.
module reg_file_param #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  input  logic [ADDR_W-1:0]   rd_addr3,
  input  logic [ADDR_W-1:0]   wr_addr1,
  input  logic [ADDR_W-1:0]   wr_addr2,
  input  logic [2*DATA_W-1:0] wr_data,
  input  logic                wr_en1,
  input  logic                wr_en2,
  input  logic                clear_req,
  output logic [DATA_W-1:0]   rd_data1,
  output logic [DATA_W-1:0]   rd_data2,
  output logic [DATA_W-1:0]   rd_data3,
  output logic                busy,
  output logic                clear_done
);

  localparam int IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] NUM_REGS_L = IDX_W'(NUM_REGS);

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_W-1:0]       regs_q [NUM_REGS];
  logic [DATA_W-1:0]       regs_d [NUM_REGS];

  logic [DATA_W-1:0]       wr_hi, wr_lo;
  logic                    wr_allow, bypass_en;
  logic [ADDR_W-1:0]       rd_addr [3];
  logic [DATA_W-1:0]       rd_data [3];

  assign wr_hi     = wr_data[2*DATA_W-1:DATA_W];
  assign wr_lo     = wr_data[DATA_W-1:0];
  assign wr_allow  = (state_q != ST_CLEAR);
  assign bypass_en = (BYPASS != 0) && wr_allow && !rst;

  assign rd_addr[0] = rd_addr1;
  assign rd_addr[1] = rd_addr2;
  assign rd_addr[2] = rd_addr3;
  assign rd_data1   = rd_data[0];
  assign rd_data2   = rd_data[1];
  assign rd_data3   = rd_data[2];

  assign busy       = (state_q == ST_CLEAR);
  assign clear_done = (state_q == ST_DONE);

  // Out-of-range addresses match no entry, so they read 0 and never forward.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd_data[p] = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (rd_addr[p] == ADDR_W'(i)) rd_data[p] = regs_q[i];
      end
      if (bypass_en && ({1'b0, rd_addr[p]} < NUM_REGS_L)) begin
        if (wr_en1 && (wr_addr1 == rd_addr[p])) rd_data[p] = wr_hi;
        if (wr_en2 && (wr_addr2 == rd_addr[p])) rd_data[p] = wr_lo;
      end
    end
  end

  // NOTE: every variable gets its hold value first so no latch is inferred,
  // and later assignments win, which gives port 2 priority on a collision.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (!wr_allow) begin
        if (idx_q == IDX_W'(i)) regs_d[i] = '0;
      end else begin
        if (wr_en1 && (wr_addr1 == ADDR_W'(i))) regs_d[i] = wr_hi;
        if (wr_en2 && (wr_addr2 == ADDR_W'(i))) regs_d[i] = wr_lo;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the storage array is reset on purpose: a reset must leave every
  // register reading 0, so it cannot be mapped onto a reset-less RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      regs_q  <= regs_d;
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: default, BYPASS=0 and a 5 x 16-bit
// instance, checked against hand-computed values.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_addr1, rd_addr2, rd_addr3, wr_addr1, wr_addr2;
  logic [15:0] wr_data;
  logic        wr_en1, wr_en2, clear_req;
  logic [7:0]  d_rd1, d_rd2, d_rd3, b_rd1, b_rd2, b_rd3;
  logic        d_busy, d_done, b_busy, b_done;

  logic [2:0]  n_rd_addr1, n_rd_addr2, n_rd_addr3, n_wr_addr1, n_wr_addr2;
  logic [31:0] n_wr_data;
  logic        n_wr_en1, n_wr_en2, n_clear_req;
  logic [15:0] n_rd1, n_rd2, n_rd3;
  logic        n_busy, n_done;

  int total = 0;
  int bad   = 0;
  int cnt;

  always #5 clk = ~clk;

  reg_file_param u_dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
    .wr_addr1(wr_addr1), .wr_addr2(wr_addr2), .wr_data(wr_data),
    .wr_en1(wr_en1), .wr_en2(wr_en2), .clear_req(clear_req),
    .rd_data1(d_rd1), .rd_data2(d_rd2), .rd_data3(d_rd3),
    .busy(d_busy), .clear_done(d_done)
  );

  reg_file_param #(.BYPASS(0)) u_nb (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
    .wr_addr1(wr_addr1), .wr_addr2(wr_addr2), .wr_data(wr_data),
    .wr_en1(wr_en1), .wr_en2(wr_en2), .clear_req(clear_req),
    .rd_data1(b_rd1), .rd_data2(b_rd2), .rd_data3(b_rd3),
    .busy(b_busy), .clear_done(b_done)
  );

  reg_file_param #(.DATA_W(16), .NUM_REGS(5)) u_n5 (
    .clk(clk), .rst(rst),
    .rd_addr1(n_rd_addr1), .rd_addr2(n_rd_addr2), .rd_addr3(n_rd_addr3),
    .wr_addr1(n_wr_addr1), .wr_addr2(n_wr_addr2), .wr_data(n_wr_data),
    .wr_en1(n_wr_en1), .wr_en2(n_wr_en2), .clear_req(n_clear_req),
    .rd_data1(n_rd1), .rd_data2(n_rd2), .rd_data3(n_rd3),
    .busy(n_busy), .clear_done(n_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    {rd_addr1, rd_addr2, rd_addr3, wr_addr1, wr_addr2} = '0;
    wr_data = '0; wr_en1 = 0; wr_en2 = 0; clear_req = 0;
    {n_rd_addr1, n_rd_addr2, n_rd_addr3, n_wr_addr1, n_wr_addr2} = '0;
    n_wr_data = '0; n_wr_en1 = 0; n_wr_en2 = 0; n_clear_req = 0;

    // Reset state
    #7;
    check("rst_rd1", 32'(d_rd1), 32'h0);
    check("rst_busy", 32'(d_busy), 32'h0);
    check("rst_done", 32'(d_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Dual write, upper half to port 1 and lower half to port 2
    wr_en1 = 1; wr_en2 = 1; wr_addr1 = 2'd1; wr_addr2 = 2'd2; wr_data = 16'hA55A;
    rd_addr1 = 2'd1; rd_addr2 = 2'd2; #1;
    check("byp_p1", 32'(d_rd1), 32'hA5);
    check("byp_p2", 32'(d_rd2), 32'h5A);
    check("nobyp_p1", 32'(b_rd1), 32'h00);
    step();
    wr_en1 = 0; wr_en2 = 0; #1;
    check("wr_p1", 32'(d_rd1), 32'hA5);
    check("wr_p2", 32'(d_rd2), 32'h5A);
    check("nb_wr_p2", 32'(b_rd2), 32'h5A);

    // Same-address collision: port 2 wins, forwarded only with BYPASS=1
    wr_en1 = 1; wr_en2 = 1; wr_addr1 = 2'd3; wr_addr2 = 2'd3; wr_data = 16'h1234;
    rd_addr3 = 2'd3; #1;
    check("coll_byp", 32'(d_rd3), 32'h34);
    check("coll_nb_old", 32'(b_rd3), 32'h00);
    step();
    wr_en1 = 0; wr_en2 = 0; #1;
    check("coll_dut", 32'(d_rd3), 32'h34);
    check("coll_nb", 32'(b_rd3), 32'h34);

    // Port 1 alone: lower half must not be written anywhere
    wr_en1 = 1; wr_addr1 = 2'd0; wr_addr2 = 2'd3; wr_data = 16'h7766; rd_addr1 = 2'd0; #1;
    check("p1_byp", 32'(d_rd1), 32'h77);
    step();
    wr_en1 = 0; #1;
    check("p1_store", 32'(d_rd1), 32'h77);
    check("p1_no_p2", 32'(d_rd3), 32'h34);

    // Fill with FF; last write lands in the same cycle as clear_req
    wr_en1 = 1; wr_en2 = 1; wr_addr1 = 2'd0; wr_addr2 = 2'd1; wr_data = 16'hFFFF;
    step();
    wr_addr1 = 2'd2; wr_addr2 = 2'd3; clear_req = 1;
    step();
    // In CLEAR: a write and clear_req held high must both be ignored
    wr_en1 = 1; wr_en2 = 0; wr_addr1 = 2'd0; wr_data = 16'h7700; clear_req = 1;
    rd_addr1 = 2'd0; rd_addr2 = 2'd1; rd_addr3 = 2'd2; #1;
    check("clr0_busy", 32'(d_busy), 32'h1);
    check("clr0_done", 32'(d_done), 32'h0);
    check("clr0_nobyp", 32'(d_rd1), 32'hFF);
    check("clr0_r2", 32'(d_rd3), 32'hFF);
    step(); #1;
    check("clr1_r0", 32'(d_rd1), 32'h00);
    check("clr1_r1", 32'(d_rd2), 32'hFF);
    check("clr1_busy", 32'(d_busy), 32'h1);
    step(); #1;
    check("clr2_r1", 32'(d_rd2), 32'h00);
    check("clr2_r2", 32'(d_rd3), 32'hFF);
    step(); #1;
    check("clr3_r2", 32'(d_rd3), 32'h00);
    rd_addr1 = 2'd3; #1;
    check("clr3_r3", 32'(d_rd1), 32'hFF);
    check("clr3_busy", 32'(d_busy), 32'h1);
    step();
    wr_en1 = 0; #1;
    check("done_busy", 32'(d_busy), 32'h0);
    check("done_pulse", 32'(d_done), 32'h1);
    check("done_nb_pulse", 32'(b_done), 32'h1);
    check("done_r3", 32'(d_rd1), 32'h00);
    rd_addr1 = 2'd0; #1;
    check("done_r0", 32'(d_rd1), 32'h00);
    check("done_r1", 32'(d_rd2), 32'h00);
    step();
    clear_req = 0; #1;
    check("post_busy", 32'(d_busy), 32'h0);
    check("post_done", 32'(d_done), 32'h0);

    // Reset two cycles into a clear
    wr_en1 = 1; wr_en2 = 1; wr_addr1 = 2'd0; wr_addr2 = 2'd1; wr_data = 16'h1122;
    step();
    wr_addr1 = 2'd2; wr_addr2 = 2'd3; wr_data = 16'h3344; clear_req = 1;
    step();
    wr_en1 = 0; wr_en2 = 0; clear_req = 0;
    step();
    step();
    rd_addr1 = 2'd2; rd_addr2 = 2'd3; rd_addr3 = 2'd1; #1;
    check("abort_pre_busy", 32'(d_busy), 32'h1);
    check("abort_pre_r2", 32'(d_rd1), 32'h33);
    check("abort_pre_r3", 32'(d_rd2), 32'h44);
    check("abort_pre_r1", 32'(d_rd3), 32'h00);
    rst = 1; #1;
    check("abort_r2", 32'(d_rd1), 32'h00);
    check("abort_r3", 32'(d_rd2), 32'h00);
    check("abort_busy", 32'(d_busy), 32'h0);
    wr_en1 = 1; wr_addr1 = 2'd2; wr_data = 16'h5500; clear_req = 1; #1;
    check("rst_nobyp", 32'(d_rd1), 32'h00);
    step();
    step();
    check("rst_nowr", 32'(d_rd1), 32'h00);
    check("rst_noclr", 32'(d_busy), 32'h0);
    wr_en1 = 0; clear_req = 0; rst = 0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (d_done || d_busy) cnt++;
    end
    check("abort_no_pulse", 32'(cnt), 32'h0);
    check("abort_r2_idle", 32'(d_rd1), 32'h00);

    // Five 16-bit registers: out-of-range write ignored, read returns 0
    n_wr_en1 = 1; n_wr_addr1 = 3'd6; n_wr_en2 = 1; n_wr_addr2 = 3'd4;
    n_wr_data = 32'hBEEF_1111; n_rd_addr1 = 3'd6; n_rd_addr2 = 3'd4; n_rd_addr3 = 3'd2; #1;
    check("n5_oor_byp", 32'(n_rd1), 32'h0);
    check("n5_byp4", 32'(n_rd2), 32'h1111);
    step();
    n_wr_en1 = 0; n_wr_en2 = 0; #1;
    check("n5_oor_rd", 32'(n_rd1), 32'h0);
    check("n5_r4", 32'(n_rd2), 32'h1111);
    check("n5_r2", 32'(n_rd3), 32'h0);
    n_clear_req = 1;
    step();
    n_clear_req = 0; #1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (!n_busy) break;
      cnt++;
      step();
    end
    check("n5_clr_cycles", 32'(cnt), 32'd5);
    check("n5_done", 32'(n_done), 32'h1);
    check("n5_r4_clr", 32'(n_rd2), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
